// File: rtl/edge_receiver_ack.sv
// Receive side of a 4-phase req/ack crossing: synchronises the foreign request and
// presents it as one valid/ready transfer. The ack is returned only after acceptance.
module edge_receiver_ack #(
    parameter int unsigned SyncStages = 2,
    parameter int unsigned CntWidth   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_async_i,
    output logic                ack_o,
    output logic                valid_o,
    input  logic                ready_i,
    input  logic                clr_i,
    output logic [CntWidth-1:0] evt_cnt_o,
    output logic                proto_err_o
);

    typedef enum logic [1:0] {StIdle, StPend, StAck} state_e;

    state_e                state_q, state_d;
    logic [SyncStages-1:0] sync_q;
    logic                  req_s;
    logic                  valid_q, ack_q;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  accept, err_set;

    assign req_s = sync_q[SyncStages-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], req_async_i};
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        err_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_s) state_d = StPend;
            end
            StPend: begin
                // A withdrawn request is a protocol error; it still counts if taken this edge.
                if (!req_s) begin
                    err_set = 1'b1;
                    accept  = ready_i;
                    state_d = StIdle;
                end else if (ready_i) begin
                    accept  = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                if (!req_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept)  cnt_d = cnt_q + 1'b1;
        if (err_set) err_d = 1'b1;
        if (clr_i) begin
            cnt_d = '0;
            err_d = 1'b0;
        end
    end

    // Outputs come straight from flops so the foreign domain never sees a glitch on ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == StPend);
            ack_q   <= (state_d == StAck);
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign valid_o     = valid_q;
    assign ack_o       = ack_q;
    assign evt_cnt_o   = cnt_q;
    assign proto_err_o = err_q;

endmodule

// File: tb/tb_edge_receiver_ack.sv
// Bench for edge_receiver_ack: vector table, directed corner sequences and a randomised
// 4-phase sender checked against a transaction-level count model.
module tb_edge_receiver_ack;

    localparam int unsigned SyncStages = 2;
    localparam int unsigned CntWidth   = 4;
    localparam int          WaitLimit  = 200;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                req = 1'b0;
    logic                ready = 1'b0;
    logic                clr = 1'b0;
    logic                ack, valid, err;
    logic [CntWidth-1:0] cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    edge_receiver_ack #(
        .SyncStages(SyncStages),
        .CntWidth  (CntWidth)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_async_i(req),
        .ack_o      (ack),
        .valid_o    (valid),
        .ready_i    (ready),
        .clr_i      (clr),
        .evt_cnt_o  (cnt),
        .proto_err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req, ready, clr;
        logic       valid, ack;
        logic [3:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic rq, logic rd, logic cl, logic v, logic a, logic [3:0] c,
                                logic e);
        vec_t r;
        r.req = rq; r.ready = rd; r.clr = cl; r.valid = v; r.ack = a; r.cnt = c; r.err = e;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_ack", ack, 0);
        check("rst_valid", valid, 0);
        check("rst_cnt", cnt, 0);
        check("rst_err", err, 0);
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        int n = 0;
        while (ack !== lvl && n < WaitLimit) begin
            tick();
            n++;
        end
        check(name, ack, lvl);
    endtask

    task automatic handshake(input int hold);
        req = 1'b1;
        wait_ack(1'b1, "hs_ack_rise");
        repeat (hold) tick();
        req = 1'b0;
        wait_ack(1'b0, "hs_ack_fall");
    endtask

    // Transaction monitor for the random phase.
    logic mon_en   = 1'b0;
    logic ack_prev = 1'b0;
    int   accepts  = 0;
    int   rises    = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid && ready) accepts++;
            if (ack && !ack_prev) begin
                rises++;
                check("ack_after_accept", accepts >= rises, 1);
            end
            check("valid_ack_exclusive", valid && ack, 0);
        end
        ack_prev = ack;
    end

    logic rand_done = 1'b0;

    initial begin
        int sent;
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 1, 0, 0, 0);
        vecs[3]  = mk(1, 1, 0, 0, 1, 1, 0);
        vecs[4]  = mk(1, 1, 0, 0, 1, 1, 0);
        vecs[5]  = mk(0, 1, 0, 0, 1, 1, 0);
        vecs[6]  = mk(0, 1, 0, 0, 1, 1, 0);
        vecs[7]  = mk(0, 1, 0, 0, 0, 1, 0);
        vecs[8]  = mk(1, 0, 0, 0, 0, 1, 0);
        vecs[9]  = mk(1, 0, 0, 0, 0, 1, 0);
        vecs[10] = mk(1, 0, 0, 1, 0, 1, 0);
        vecs[11] = mk(0, 0, 0, 1, 0, 1, 0);
        vecs[12] = mk(0, 0, 0, 1, 0, 1, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 1, 1);
        vecs[14] = mk(0, 0, 1, 0, 0, 0, 0);
        vecs[15] = mk(0, 1, 0, 0, 0, 0, 0);

        do_reset();

        // Basic latency, ack fall, protocol violation and clear.
        for (int i = 0; i < 16; i++) begin
            req = vecs[i].req; ready = vecs[i].ready; clr = vecs[i].clr;
            tick();
            check($sformatf("vec%0d_valid", i), valid, vecs[i].valid);
            check($sformatf("vec%0d_ack", i), ack, vecs[i].ack);
            check($sformatf("vec%0d_cnt", i), cnt, vecs[i].cnt);
            check($sformatf("vec%0d_err", i), err, vecs[i].err);
        end
        clr = 1'b0;

        // Backpressure: valid held for 10 cycles, then accepted.
        do_reset();
        req = 1'b1; ready = 1'b0;
        repeat (SyncStages + 1) tick();
        check("bp_valid_rise", valid, 1);
        repeat (10) begin
            tick();
            check("bp_valid_hold", valid, 1);
            check("bp_ack_low", ack, 0);
            check("bp_cnt_hold", cnt, 0);
        end
        ready = 1'b1;
        tick();
        check("bp_ack", ack, 1);
        check("bp_valid_drop", valid, 0);
        check("bp_cnt", cnt, 1);
        req = 1'b0;
        wait_ack(1'b0, "bp_ack_fall");

        // Wrap after 16 transfers, then clear coincident with acceptance.
        do_reset();
        ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            handshake(i % 3);
            check("wrap_cnt", cnt, i % 16);
        end
        ready = 1'b0; req = 1'b1;
        repeat (SyncStages + 1) tick();
        check("clr_pend_valid", valid, 1);
        ready = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_acc_ack", ack, 1);
        check("clr_acc_cnt", cnt, 0);
        req = 1'b0;
        wait_ack(1'b0, "clr_ack_fall");

        // Asynchronous reset while in ACK.
        do_reset();
        ready = 1'b1; req = 1'b1;
        wait_ack(1'b1, "ar_ack_rise");
        check("ar_cnt_pre", cnt, 1);
        #3 rst = 1'b1;
        #1;
        check("ar_ack", ack, 0);
        check("ar_valid", valid, 0);
        check("ar_cnt", cnt, 0);
        #1 rst = 1'b0;
        req = 1'b0;
        repeat (4) tick();
        check("ar_idle_ack", ack, 0);
        handshake(1);
        check("ar_fresh_cnt", cnt, 1);

        // Request held high across reset release.
        req = 1'b1; ready = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        repeat (SyncStages) tick();
        check("held_valid_early", valid, 0);
        tick();
        check("held_valid", valid, 1);
        ready = 1'b1;
        tick();
        check("held_ack", ack, 1);
        check("held_cnt", cnt, 1);
        req = 1'b0;
        wait_ack(1'b0, "held_ack_fall");

        // Random sender timing and consumer readiness.
        do_reset();
        sent = 0;
        mon_en = 1'b1;
        fork
            begin
                while (!rand_done) begin
                    ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join_none
        for (int t = 0; t < 1000; t++) begin
            repeat ($urandom_range(0, 3)) tick();
            req = 1'b1;
            wait_ack(1'b1, "rnd_ack_rise");
            sent++;
            check("rnd_cnt", cnt, sent % (1 << CntWidth));
            repeat ($urandom_range(0, 3)) tick();
            req = 1'b0;
            wait_ack(1'b0, "rnd_ack_fall");
        end
        rand_done = 1'b1;
        tick();
        mon_en = 1'b0;
        check("rnd_err", err, 0);
        check("rnd_accepts", accepts, sent);
        check("rnd_rises", rises, sent);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
